// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and opcode helper for the MCP23S17 SPI master
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP
    } spi_mst_state_t;

    localparam logic [3:0] MCP_OPCODE_HI = 4'b0100;

    function automatic logic [7:0] mcp_opcode(input logic [2:0] hw_addr, input logic rw);
        return {MCP_OPCODE_HI, hw_addr, rw};
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// rtl/spi_clk_tick.sv - SCLK half-period divider producing a one-clk tick
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mcp23s17_spi_master.sv
// rtl/mcp23s17_spi_master.sv - mode-0 SPI initiator issuing MCP23S17 register frames
module mcp23s17_spi_master
    import spi_pkg::*;
#(
    parameter int         CLK_DIV = 4,
    parameter logic [2:0] HW_ADDR = 3'b000,
    parameter int         MAX_RD  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] wdata_i,
    input  logic [1:0] rd_len_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       rdata_vld_o,
    output logic       sclk_o,
    output logic       csn_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int BW = $clog2(MAX_RD + 3);

    spi_mst_state_t state, state_d;

    logic          tick;
    logic          accept;
    logic          do_rise;
    logic          do_fall;
    logic          last_fall;
    logic          rw_q;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [BW-1:0] nbytes_q;
    logic [BW-1:0] byte_idx;
    logic [2:0]    bit_idx;
    logic [6:0]    rx_q;
    logic [BW-1:0] rd_bytes;
    logic [BW-1:0] frame_bytes;
    logic [7:0]    tx_byte;

    spi_clk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rstn(rstn),
        .en  (state != IDLE),
        .clr (accept),
        .tick(tick)
    );

    // Frame length is fixed here from the live command inputs and latched at accept.
    always_comb begin
        rd_bytes = BW'(rd_len_i);
        if (rd_len_i == 2'd0) begin
            rd_bytes = BW'(1);
        end else if (int'(rd_len_i) > MAX_RD) begin
            rd_bytes = BW'(MAX_RD);
        end
        frame_bytes = rw_i ? (BW'(2) + rd_bytes) : BW'(3);
    end

    always_comb begin
        tx_byte = rw_q ? 8'h00 : wdata_q;
        if (byte_idx == BW'(0)) begin
            tx_byte = mcp_opcode(HW_ADDR, rw_q);
        end else if (byte_idx == BW'(1)) begin
            tx_byte = addr_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The done cycle doubles as an idle slot so a held start_i restarts with one GAP of CS high.
    always_comb begin
        state_d   = state;
        busy_o    = (state != IDLE);
        done_o    = 1'b0;
        accept    = 1'b0;
        do_rise   = 1'b0;
        do_fall   = 1'b0;
        last_fall = 1'b0;
        case (state)
            IDLE: begin
                accept = start_i;
                if (start_i) begin
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    do_rise = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_o) begin
                        do_rise = 1'b1;
                    end else begin
                        do_fall = 1'b1;
                        if (byte_idx == nbytes_q) begin
                            last_fall = 1'b1;
                            state_d   = CS_HOLD;
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    done_o  = 1'b1;
                    busy_o  = 1'b0;
                    accept  = start_i;
                    state_d = start_i ? CS_SETUP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csn_o       <= 1'b1;
            sclk_o      <= 1'b0;
            mosi_o      <= 1'b0;
            rdata_o     <= 8'h00;
            rdata_vld_o <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            nbytes_q    <= '0;
            byte_idx    <= '0;
            bit_idx     <= 3'd7;
            rx_q        <= 7'h00;
        end else begin
            rdata_vld_o <= 1'b0;
            if (accept) begin
                rw_q     <= rw_i;
                addr_q   <= reg_addr_i;
                wdata_q  <= wdata_i;
                nbytes_q <= frame_bytes;
                byte_idx <= '0;
                bit_idx  <= 3'd7;
                csn_o    <= 1'b0;
                sclk_o   <= 1'b0;
                mosi_o   <= mcp_opcode(HW_ADDR, rw_i) >> 7;
            end
            if (do_rise) begin
                sclk_o  <= 1'b1;
                rx_q    <= {rx_q[5:0], miso_i};
                bit_idx <= bit_idx - 3'd1;
                if (bit_idx == 3'd0) begin
                    byte_idx <= byte_idx + BW'(1);
                    if (rw_q && (byte_idx >= BW'(2))) begin
                        rdata_o     <= {rx_q, miso_i};
                        rdata_vld_o <= 1'b1;
                    end
                end
            end
            if (do_fall) begin
                sclk_o <= 1'b0;
                mosi_o <= last_fall ? 1'b0 : tx_byte[bit_idx];
            end
            if ((state == CS_HOLD) && tick) begin
                csn_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mcp23s17_spi_master.sv
// tb/tb_mcp23s17_spi_master.sv - directed bench with an MCP23S17 responder model
module tb_mcp23s17_spi_master;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       start_a, rw_a, busy_a, done_a, vld_a, sclk_a, csn_a, mosi_a;
    logic       miso_a = 1'b0;
    logic [7:0] addr_a, wdata_a, rdata_a;
    logic [1:0] len_a;

    logic       start_b, rw_b, busy_b, done_b, vld_b, sclk_b, csn_b, mosi_b;
    logic       miso_b = 1'b0;
    logic [7:0] addr_b, wdata_b, rdata_b;
    logic [1:0] len_b;

    mcp23s17_spi_master #(.CLK_DIV(4), .HW_ADDR(3'b000), .MAX_RD(2)) dut_a (
        .clk(clk), .rstn(rstn), .start_i(start_a), .rw_i(rw_a), .reg_addr_i(addr_a),
        .wdata_i(wdata_a), .rd_len_i(len_a), .busy_o(busy_a), .done_o(done_a),
        .rdata_o(rdata_a), .rdata_vld_o(vld_a), .sclk_o(sclk_a), .csn_o(csn_a),
        .mosi_o(mosi_a), .miso_i(miso_a)
    );

    mcp23s17_spi_master #(.CLK_DIV(1), .HW_ADDR(3'b000), .MAX_RD(2)) dut_b (
        .clk(clk), .rstn(rstn), .start_i(start_b), .rw_i(rw_b), .reg_addr_i(addr_b),
        .wdata_i(wdata_b), .rd_len_i(len_b), .busy_o(busy_b), .done_o(done_b),
        .rdata_o(rdata_b), .rdata_vld_o(vld_b), .sclk_o(sclk_b), .csn_o(csn_b),
        .mosi_o(mosi_b), .miso_i(miso_b)
    );

    int total = 0;
    int bad = 0;

    // Responder: samples MOSI on SCLK rise, drives MISO on SCLK fall, sequential register reads.
    logic [7:0] mem [256];
    logic [7:0] r_bytes [$];
    logic [7:0] r_sh = 8'h00;
    logic [7:0] r_op = 8'h00;
    logic [7:0] r_addr = 8'h00;
    logic [7:0] data_rcv = 8'h00;
    int         r_bits = 0;

    always @(posedge sclk_a or posedge csn_a) begin
        if (csn_a) begin
            r_bits = 0;
        end else begin
            r_sh = {r_sh[6:0], mosi_a};
            r_bits++;
            if (r_bits % 8 == 0) begin
                r_bytes.push_back(r_sh);
                if (r_bits == 8) r_op = r_sh;
                else if (r_bits == 16) r_addr = r_sh;
                else if (!r_op[0]) data_rcv = r_sh;
            end
        end
    end

    always @(negedge sclk_a) begin
        if (!csn_a && r_op[0] && r_bits >= 16) begin
            miso_a = mem[8'(r_addr + 8'((r_bits - 16) / 8))][7 - (r_bits % 8)];
        end
    end

    int         done_cnt = 0;
    int         sclk_cnt = 0;
    logic [7:0] vld_q [$];

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt++;
        if (vld_a === 1'b1) vld_q.push_back(rdata_a);
    end

    always @(posedge sclk_a) if (csn_a === 1'b0) sclk_cnt++;

    int done_cnt_b = 0, hi_cnt_b = 0, lo_seen_b = 0, fsclk_b = 0;
    int sck_hi_run = 0, sck_runs = 0, sck_max = 0;
    int gaps_b [$];
    int frame_sclk_b [$];

    always @(negedge clk) begin
        if (done_b === 1'b1) done_cnt_b++;
        if (csn_b === 1'b1) begin
            hi_cnt_b++;
        end else begin
            if (lo_seen_b != 0 && hi_cnt_b > 0) gaps_b.push_back(hi_cnt_b);
            hi_cnt_b  = 0;
            lo_seen_b = 1;
        end
        if (sclk_b === 1'b1) begin
            sck_hi_run++;
        end else if (sck_hi_run > 0) begin
            sck_runs++;
            if (sck_hi_run > sck_max) sck_max = sck_hi_run;
            sck_hi_run = 0;
        end
    end

    always @(posedge sclk_b) if (csn_b === 1'b0) fsclk_b++;
    always @(posedge csn_b) begin
        if (lo_seen_b != 0) begin
            frame_sclk_b.push_back(fsclk_b);
            fsclk_b = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_a(input logic rw, input logic [7:0] a, input logic [7:0] d, input logic [1:0] l);
        @(negedge clk);
        rw_a = rw; addr_a = a; wdata_a = d; len_a = l; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (done_a !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 3000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    int d0, v0, b0, s0, n, k;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h12] = 8'hF0;
        mem[8'h13] = 8'h0F;
        rstn = 1'b0;
        start_a = 0; rw_a = 0; addr_a = 0; wdata_a = 0; len_a = 0;
        start_b = 0; rw_b = 0; addr_b = 0; wdata_b = 0; len_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_csn", csn_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_vld", vld_a, 0);
        chk("rst_rdata", rdata_a, 8'h00);
        rstn = 1'b1;
        @(negedge clk);

        // 1: write 0x5A to reg 0x0A
        d0 = done_cnt; v0 = vld_q.size(); b0 = r_bytes.size(); s0 = sclk_cnt;
        issue_a(1'b0, 8'h0A, 8'h5A, 2'd0);
        chk("t1_busy", busy_a, 1);
        chk("t1_csn_low", csn_a, 0);
        wait_done_a("t1_timeout");
        chk("t1_nbytes", r_bytes.size() - b0, 3);
        chk("t1_op", r_bytes[b0], 8'h40);
        chk("t1_addr", r_bytes[b0+1], 8'h0A);
        chk("t1_data", r_bytes[b0+2], 8'h5A);
        chk("t1_sclk", sclk_cnt - s0, 24);
        chk("t1_rcv", data_rcv, 8'h5A);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_vld", vld_q.size() - v0, 0);
        chk("t1_busy_end", busy_a, 0);

        // 2: read two bytes from reg 0x12
        d0 = done_cnt; v0 = vld_q.size(); b0 = r_bytes.size(); s0 = sclk_cnt;
        issue_a(1'b1, 8'h12, 8'hEE, 2'd2);
        wait_done_a("t2_timeout");
        chk("t2_nbytes", r_bytes.size() - b0, 4);
        chk("t2_op", r_bytes[b0], 8'h41);
        chk("t2_addr", r_bytes[b0+1], 8'h12);
        chk("t2_pad0", r_bytes[b0+2], 8'h00);
        chk("t2_pad1", r_bytes[b0+3], 8'h00);
        chk("t2_nvld", vld_q.size() - v0, 2);
        chk("t2_rd0", vld_q[v0], 8'hF0);
        chk("t2_rd1", vld_q[v0+1], 8'h0F);
        chk("t2_sclk", sclk_cnt - s0, 32);
        chk("t2_hold", rdata_a, 8'h0F);
        chk("t2_done", done_cnt - d0, 1);

        // 3: rd_len 0 -> one byte, rd_len 3 -> clamped to two
        v0 = vld_q.size(); s0 = sclk_cnt;
        issue_a(1'b1, 8'h12, 8'h00, 2'd0);
        wait_done_a("t3a_timeout");
        chk("t3a_sclk", sclk_cnt - s0, 24);
        chk("t3a_nvld", vld_q.size() - v0, 1);
        chk("t3a_rd0", vld_q[v0], 8'hF0);
        v0 = vld_q.size(); s0 = sclk_cnt;
        issue_a(1'b1, 8'h12, 8'h00, 2'd3);
        wait_done_a("t3b_timeout");
        chk("t3b_sclk", sclk_cnt - s0, 32);
        chk("t3b_nvld", vld_q.size() - v0, 2);
        chk("t3b_rd1", vld_q[v0+1], 8'h0F);

        // 4: start pulse mid-frame is ignored
        d0 = done_cnt; b0 = r_bytes.size(); s0 = sclk_cnt;
        issue_a(1'b0, 8'h0A, 8'h5A, 2'd0);
        repeat (40) @(negedge clk);
        rw_a = 1'b0; addr_a = 8'h07; wdata_a = 8'h77; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("t4_timeout");
        repeat (300) @(negedge clk);
        chk("t4_done", done_cnt - d0, 1);
        chk("t4_nbytes", r_bytes.size() - b0, 3);
        chk("t4_data", r_bytes[b0+2], 8'h5A);
        chk("t4_sclk", sclk_cnt - s0, 24);

        // 5: reset during the address byte, then a clean write
        d0 = done_cnt; v0 = vld_q.size();
        issue_a(1'b0, 8'h0A, 8'h5A, 2'd0);
        n = 0;
        while (r_bits < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_byte1", 32'(n < 2000), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_csn", csn_a, 1);
        chk("t5_sclk", sclk_a, 0);
        chk("t5_busy", busy_a, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_vld", vld_q.size() - v0, 0);
        d0 = done_cnt; b0 = r_bytes.size(); s0 = sclk_cnt;
        issue_a(1'b0, 8'h01, 8'h33, 2'd0);
        wait_done_a("t5_timeout");
        chk("t5_nbytes", r_bytes.size() - b0, 3);
        chk("t5_addr", r_bytes[b0+1], 8'h01);
        chk("t5_rcv", data_rcv, 8'h33);
        chk("t5_sclk", sclk_cnt - s0, 24);
        chk("t5_done", done_cnt - d0, 1);

        // 6: CLK_DIV=1, start held for three back-to-back frames
        d0 = done_cnt_b;
        @(negedge clk);
        rw_b = 1'b0; addr_b = 8'h05; wdata_b = 8'hA5; len_b = 2'd0; start_b = 1'b1;
        n = 0; k = 0;
        while (k < 3 && n < 1000) begin
            @(negedge clk);
            n++;
            if (done_b === 1'b1) k++;
        end
        start_b = 1'b0;
        chk("t6_timeout", 32'(n < 1000), 32'd1);
        repeat (20) @(negedge clk);
        chk("t6_done", done_cnt_b - d0, 3);
        chk("t6_ngaps", gaps_b.size(), 2);
        for (int i = 0; i < gaps_b.size(); i++) chk("t6_gap", gaps_b[i], 1);
        chk("t6_nframes", frame_sclk_b.size(), 3);
        for (int i = 0; i < frame_sclk_b.size(); i++) chk("t6_frame_sclk", frame_sclk_b[i], 24);
        chk("t6_sck_runs", sck_runs, 72);
        chk("t6_sck_half", sck_max, 1);
        chk("t6_idle_csn", csn_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
